sram_uart_bus_ctrl: RTL and testbench

//  Parametrised memory-bus controller between the pipeline MEM stage and the external

---
 rtl/sram_uart_bus_ctrl_if.sv | 18 +
 rtl/sram_uart_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sram_uart_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_uart_bus_ctrl_if.sv
// CPU-side request/response bus of the SRAM/UART memory controller.
interface sram_uart_bus_ctrl_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;

  // Pipeline MEM stage side
  modport master (output req, we, addr, wdata, input rdata, busy, done);
  // Controller side
  modport slave  (input req, we, addr, wdata, output rdata, busy, done);
endinterface

// File: rtl/sram_uart_bus_ctrl.sv
// Memory-bus controller: one request at a time from the MEM stage, sequenced onto
// an asynchronous SRAM with programmable wait states. Define MEMCTRL_UART_EN to map
// the UART data/status registers into the address space.
module sram_uart_bus_ctrl #(
  parameter int unsigned   AW         = 16,
  parameter int unsigned   DW         = 16,
  parameter int unsigned   RAM_AW     = 18,
  parameter int unsigned   WAIT_CYC   = 0,
  parameter logic [AW-1:0] UART_DADDR = AW'(16'hBF00),
  parameter logic [AW-1:0] UART_SADDR = AW'(16'hBF01)
) (
  input  logic              CLK,
  input  logic              RST,
  sram_uart_bus_ctrl_if.slave bus,
  output logic              ramEN,
  output logic              ramOE,
  output logic              ramWE,
  output logic [RAM_AW-1:0] ramAddr,
  inout  wire  [DW-1:0]     ramData,
  input  logic              tbre,
  input  logic              tsre,
  input  logic              data_ready,
  output logic              rdn,
  output logic              wrn
);

  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_U_WAIT, S_U_STRB, S_U_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              uart_q, uart_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              drv_q, drv_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              accept;
  logic              mem_cyc;

  // Next state, latched request and captured read data
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    uart_d  = uart_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.req) accept = 1'b1;
        else         state_d = S_IDLE;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (cnt_q == CW'(WAIT_CYC)) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ramData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MEMCTRL_UART_EN
      S_U_WAIT: begin
        if (data_ready) begin
          state_d = S_U_STRB;
          cnt_d   = '0;
        end
      end
      S_U_STRB: begin
        if (cnt_q == CW'(1)) begin
          state_d = we_q ? S_U_DRAIN : S_DONE;
          if (!we_q) rdata_d = {{(DW-8){1'b0}}, ramData[7:0]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_U_DRAIN: begin
        if (tbre && tsre) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // New request from IDLE or straight out of DONE (back-to-back)
    if (accept) begin
      we_d    = bus.we;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
      uart_d  = 1'b0;
      cnt_d   = '0;
      state_d = S_SETUP;
`ifdef MEMCTRL_UART_EN
      if (bus.addr == UART_SADDR) begin
        uart_d  = 1'b1;
        state_d = S_DONE;
        if (!bus.we) rdata_d = {{(DW-2){1'b0}}, data_ready, tbre & tsre};
      end else if (bus.addr == UART_DADDR) begin
        uart_d  = 1'b1;
        state_d = bus.we ? S_U_STRB : S_U_WAIT;
      end
`endif
    end
  end

  // Registered bus controls derived from the upcoming state
  always_comb begin
    mem_cyc    = (state_d == S_SETUP || state_d == S_ACCESS || state_d == S_DONE) && !uart_d;
    ram_en_d   = !mem_cyc;
    ram_oe_d   = !(state_d == S_ACCESS && !we_d);
    ram_we_d   = !(state_d == S_ACCESS && we_d);
    ram_addr_d = (state_d == S_SETUP) ? RAM_AW'(addr_d) : ram_addr_q;
    drv_d      = (mem_cyc && we_d) || (state_d == S_U_STRB && we_d);
    dout_d     = uart_d ? {{(DW-8){1'b0}}, wdata_d[7:0]} : wdata_d;
    busy_d     = !(state_d == S_IDLE || state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    rdn_d      = !(state_d == S_U_STRB && !we_d);
    wrn_d      = !(state_d == S_U_STRB && we_d);
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      uart_q     <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ram_en_q   <= 1'b1;
      ram_oe_q   <= 1'b1;
      ram_we_q   <= 1'b1;
      ram_addr_q <= '0;
      drv_q      <= 1'b0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      uart_q     <= uart_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ram_en_q   <= ram_en_d;
      ram_oe_q   <= ram_oe_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      drv_q      <= drv_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdn_q      <= rdn_d;
      wrn_q      <= wrn_d;
    end
  end

`ifndef MEMCTRL_UART_EN
  // UART status inputs have no function without the UART mapping
  logic unused_uart_in;
  assign unused_uart_in = ^{tbre, tsre, data_ready};
`endif

  assign ramData    = drv_q ? dout_q : {DW{1'bz}};
  assign ramEN      = ram_en_q;
  assign ramOE      = ram_oe_q;
  assign ramWE      = ram_we_q;
  assign ramAddr    = ram_addr_q;
  assign rdn        = rdn_q;
  assign wrn        = wrn_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_sram_uart_bus_ctrl.sv
// Bench for sram_uart_bus_ctrl: directed and random accesses against an SRAM model
// and a word-array reference memory. UART cases run when MEMCTRL_UART_EN is defined.
module tb_sram_uart_bus_ctrl;
  localparam int unsigned AW = 16, DW = 16, RAM_AW = 18;
  localparam int WAIT = 3;
  localparam int LIMIT = 200;

  logic clk, rst_n;
  logic ram_en, ram_oe, ram_we, rdn, wrn;
  logic [RAM_AW-1:0] ram_addr;
  tri0  [DW-1:0] ram_data;
  logic tbre, tsre, data_ready;
  logic [15:0] uart_rx;

  sram_uart_bus_ctrl_if #(.AW(AW), .DW(DW)) bus_if ();

  sram_uart_bus_ctrl #(.AW(AW), .DW(DW), .RAM_AW(RAM_AW), .WAIT_CYC(WAIT)) u_dut (
    .CLK(clk), .RST(rst_n), .bus(bus_if.slave),
    .ramEN(ram_en), .ramOE(ram_oe), .ramWE(ram_we), .ramAddr(ram_addr), .ramData(ram_data),
    .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Initial SRAM contents: a fixed address-derived pattern
  function automatic logic [15:0] pat(input int i);
    return 16'(i) ^ 16'h5AC3;
  endfunction

  // SRAM model: words written through the bus override the pattern
  logic [15:0] mem [0:65535];
  bit          wr_flag [0:65535];
  logic [15:0] ref_mem [0:65535];

  function automatic logic [15:0] sram_word(input logic [15:0] a);
    return wr_flag[a] ? mem[a] : pat(int'(a));
  endfunction

  always @(posedge ram_we)
    if (rst_n && !ram_en) begin
      mem[ram_addr[15:0]]     = ram_data;
      wr_flag[ram_addr[15:0]] = 1'b1;
    end

  logic        tb_drv;
  logic [15:0] tb_val;
  assign tb_drv   = (!ram_en && !ram_oe) || !rdn;
  assign tb_val   = !rdn ? uart_rx : sram_word(ram_addr[15:0]);
  assign ram_data = tb_drv ? tb_val : 16'hzzzz;

  // Bus-protocol monitors
  int both_low = 0, we_addr_chg = 0;
  logic [RAM_AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!ram_oe && !ram_we) both_low++;
    if (!ram_we && ram_addr !== prev_addr) we_addr_chg++;
    prev_addr = ram_addr;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SRAM access from the cycle req is raised; keep leaves req high at done
  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input bit keep, input string tag);
    int lat, bsy, strb, abad, dbad;
    logic [15:0] rd;
    bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d;
    lat = 0; bsy = 0; strb = 0; abad = 0; dbad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus_if.busy) bsy++;
      if (!ram_oe || !ram_we) strb++;
      if (!ram_en && ram_addr !== RAM_AW'(a)) abad++;
      if (w && !ram_en && ram_data !== d) dbad++;
      if (bus_if.busy) begin
        bus_if.we = 1'($urandom); bus_if.addr = 16'($urandom); bus_if.wdata = 16'($urandom);
      end
    end while (!bus_if.done && lat < LIMIT);
    rd = bus_if.rdata;
    chk({tag, "_latency"}, 32'(lat), 32'(WAIT + 3));
    chk({tag, "_busy_cycles"}, 32'(bsy), 32'(WAIT + 2));
    chk({tag, "_strobe_cycles"}, 32'(strb), 32'(WAIT + 1));
    chk({tag, "_addr"}, 32'(abad), 32'd0);
    if (w) begin
      chk({tag, "_wdata_bus"}, 32'(dbad), 32'd0);
      ref_mem[a] = d;
    end else begin
      chk({tag, "_rdata"}, 32'(rd), 32'(ref_mem[a]));
    end
    if (!keep) begin
      bus_if.req = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'({bus_if.done, bus_if.busy}), 32'd0);
    end
  endtask

  logic [15:0] pool [6];
  logic        rw;
  logic [15:0] ra, rdv;
  bit          rk;
  int          lat, lowc, enbad, bad;

  initial begin
    rst_n = 1'b0;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0; uart_rx = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ctrl", 32'({ram_en, ram_oe, ram_we}), 32'h7);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    chk("rst_busy_done", 32'({bus_if.busy, bus_if.done}), 32'd0);
    chk("rst_uart_strb", 32'({rdn, wrn}), 32'h3);
    chk("rst_bus_released", 32'(ram_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back, a preloaded-value read, and a back-to-back pair
    xfer(1'b1, 16'h0010, 16'h1234, 1'b0, "t1_wr");
    xfer(1'b0, 16'h0010, 16'h0000, 1'b0, "t1_rd");
    xfer(1'b1, 16'h0020, 16'hBEEF, 1'b0, "t2_wr");
    xfer(1'b0, 16'h0020, 16'h0000, 1'b0, "t2_rd");
    xfer(1'b1, 16'h0001, 16'h0BB1, 1'b1, "t3_wr");
    xfer(1'b0, 16'h0002, 16'h0000, 1'b0, "t3_rd");

    // Reset during the write strobe
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 16'h0040; bus_if.wdata = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    chk("t4_mid_write", 32'(ram_we), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_ctrl", 32'({ram_en, ram_oe, ram_we}), 32'h7);
    chk("t4_bus_released", 32'(ram_data), 32'd0);
    chk("t4_busy_done", 32'({bus_if.busy, bus_if.done}), 32'd0);
    bus_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_sram_unchanged", 32'(sram_word(16'h0040)), 32'(ref_mem[16'h0040]));
    xfer(1'b0, 16'h0040, 16'h0000, 1'b0, "t4_rd");

`ifndef MEMCTRL_UART_EN
    // UART addresses behave as plain SRAM
    xfer(1'b1, 16'hBF00, 16'hAA55, 1'b0, "plain_bf00_wr");
    xfer(1'b0, 16'hBF00, 16'h0000, 1'b0, "plain_bf00_rd");
`endif

    // Random traffic over a small address pool
    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom) & 16'h7FFF;
    for (int n = 0; n < 30; n++) begin
      rw = 1'($urandom);
      ra = pool[$urandom_range(0, 5)];
      rdv = 16'($urandom);
      rk = ($urandom_range(0, 3) == 0);
      xfer(rw, ra, rdv, rk, "rnd");
    end
    xfer(1'b0, pool[0], 16'h0000, 1'b0, "rnd_last");

`ifdef MEMCTRL_UART_EN
    // UART data read: wait for data_ready, then a two-cycle rdn strobe
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0; uart_rx = 16'hFF41;
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = 16'hBF00; bus_if.wdata = '0;
    lowc = 0; enbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rdn) lowc++;
      if (!ram_en) enbad++;
    end
    chk("t5_wait_rdn", 32'(lowc), 32'd0);
    chk("t5_wait_busy", 32'(bus_if.busy), 32'd1);
    data_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rdn) lowc++;
      if (!ram_en) enbad++;
    end while (!bus_if.done && lat < LIMIT);
    chk("t5_latency", 32'(lat), 32'd3);
    chk("t5_rdn_low", 32'(lowc), 32'd2);
    chk("t5_rdata", 32'(bus_if.rdata), 32'h0041);
    bus_if.req = 1'b0;
    @(negedge clk);
    // UART status read completes without an SRAM cycle
    bus_if.req = 1'b1; bus_if.addr = 16'hBF01;
    @(negedge clk);
    chk("t5_status_done", 32'(bus_if.done), 32'd1);
    chk("t5_status_rdata", 32'(bus_if.rdata), 32'h0003);
    if (!ram_en) enbad++;
    bus_if.req = 1'b0; data_ready = 1'b0;
    @(negedge clk);
    chk("t5_ram_en", 32'(enbad), 32'd0);

    // UART data write: wrn strobe with the low byte, then drain
    tbre = 1'b0; tsre = 1'b0;
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 16'hBF00; bus_if.wdata = 16'hAA55;
    lowc = 0; enbad = 0; bad = 0; lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (!wrn) begin
        lowc++;
        if (ram_data !== 16'h0055) bad++;
      end
      if (bus_if.done) lat++;
      if (!ram_en) enbad++;
    end
    chk("t6_wrn_low", 32'(lowc), 32'd2);
    chk("t6_bus_data", 32'(bad), 32'd0);
    chk("t6_early_done", 32'(lat), 32'd0);
    tbre = 1'b1; tsre = 1'b1;
    @(negedge clk);
    chk("t6_done", 32'(bus_if.done), 32'd1);
    if (!ram_en) enbad++;
    chk("t6_ram_en", 32'(enbad), 32'd0);
    bus_if.req = 1'b0;
    @(negedge clk);
`else
    chk("uart_strobes_idle", 32'({rdn, wrn}), 32'h3);
`endif

    chk("oe_we_overlap", 32'(both_low), 32'd0);
    chk("we_during_addr_change", 32'(we_addr_chg), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
